// File: rtl/crack_pkg.sv
// Shared types and sizes for the ARC4 crack scheduler and its arbiter.
package crack_pkg;
    localparam int KEYW     = 24;
    localparam int MAXCORES = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAITC,
        START,
        RUN,
        ABORT
    } sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr.
// Latency: grant is combinational; rr_ptr moves on the clock after an advanced grant.
// Backpressure: a requester holds req until granted; worst-case wait is N cycles.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] cand;
    logic          gnt_any;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        gnt_any = 1'b0;
        // Grants are forced off while reset is asserted.
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                cand = PW'((int'(rr_ptr) + k) % N);
                if (!gnt_any && req[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
            if (gnt_any) gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance && gnt_any) begin
            rr_ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
endmodule

// File: rtl/crack_scheduler.sv
// Starts N interleaved ARC4 crack cores, shares the CT read port round-robin, reports the first valid key.
// Latency: en to core_en 2 cycles; rdy rises 1 cycle after the deciding core finish; CT data 1 cycle after grant.
// Backpressure: en is only taken while rdy=1; CT requesters hold core_ct_req until granted.
module crack_scheduler
    import crack_pkg::*;
#(
    parameter int NCORES = 2,
    parameter int KEYW   = crack_pkg::KEYW
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    output logic                         rdy,
    output logic [KEYW-1:0]              key,
    output logic                         key_valid,
    output logic [$clog2(MAXCORES)-1:0]  win_idx,
    output logic [NCORES-1:0]            core_en,
    output logic [NCORES*KEYW-1:0]       core_base,
    output logic                         core_abort,
    input  logic [NCORES-1:0]            core_rdy,
    input  logic [NCORES*KEYW-1:0]       core_key,
    input  logic [NCORES-1:0]            core_key_valid,
    input  logic [NCORES-1:0]            core_ct_req,
    input  logic [NCORES*8-1:0]          core_ct_addr,
    output logic [NCORES-1:0]            core_ct_gnt,
    output logic [NCORES-1:0]            core_ct_rvalid,
    output logic [7:0]                   core_ct_rddata,
    output logic [7:0]                   ct_addr,
    input  logic [7:0]                   ct_rddata
);
    localparam int IDXW = $clog2(MAXCORES);

    sched_state_t          state_q, state_d;
    logic [KEYW-1:0]       key_q, key_d;
    logic [IDXW-1:0]       win_q, win_d;
    logic                  key_vld_q, key_vld_d;
    logic [NCORES-1:0]     done_q, done_d;
    logic [NCORES-1:0]     core_rdy_q;
    logic                  first_q;
    logic [NCORES-1:0]     rise;
    logic [NCORES-1:0]     fin_vld;
    logic [7:0]            ct_addr_q;
    logic [7:0]            gnt_addr;
    logic [NCORES-1:0]     rvalid_q;

    // Core i walks keys i, i+NCORES, ... so its first key is simply i.
    for (genvar i = 0; i < NCORES; i++) begin : g_base
        assign core_base[i*KEYW +: KEYW] = KEYW'(i);
    end

    rr_arbiter #(.N(NCORES)) u_ct_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (core_ct_req),
        .advance (1'b1),
        .gnt     (core_ct_gnt)
    );

    always_comb begin
        gnt_addr = ct_addr_q;
        for (int i = 0; i < NCORES; i++) begin
            if (core_ct_gnt[i]) gnt_addr = core_ct_addr[i*8 +: 8];
        end
    end

    assign ct_addr        = gnt_addr;
    assign core_ct_rvalid = rvalid_q;
    assign core_ct_rddata = ct_rddata;

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        win_d     = win_q;
        key_vld_d = key_vld_q;
        done_d    = done_q;
        rise      = core_rdy & ~core_rdy_q;
        fin_vld   = rise & core_key_valid & ~done_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d   = WAITC;
                    key_vld_d = 1'b0;
                end
            end
            WAITC: begin
                if (&core_rdy) state_d = START;
            end
            START: begin
                state_d = RUN;
                done_d  = '0;
            end
            RUN: begin
                // Cores may still report rdy in the cycle right after the start pulse.
                if (!first_q) begin
                    done_d = done_q | rise;
                    if (|fin_vld) begin
                        state_d   = ABORT;
                        key_vld_d = 1'b1;
                        for (int i = NCORES - 1; i >= 0; i--) begin
                            if (fin_vld[i]) begin
                                win_d = IDXW'(i);
                                key_d = core_key[i*KEYW +: KEYW];
                            end
                        end
                    end else if (&done_d) begin
                        state_d   = IDLE;
                        key_vld_d = 1'b0;
                    end
                end
            end
            ABORT: begin
                if (&core_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            key_q      <= '0;
            win_q      <= '0;
            key_vld_q  <= 1'b0;
            done_q     <= '0;
            core_rdy_q <= '1;
            first_q    <= 1'b0;
            ct_addr_q  <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            win_q      <= win_d;
            key_vld_q  <= key_vld_d;
            done_q     <= done_d;
            core_rdy_q <= core_rdy;
            first_q    <= (state_q == START);
            ct_addr_q  <= gnt_addr;
            rvalid_q   <= core_ct_gnt;
        end
    end

    assign rdy        = (state_q == IDLE);
    assign core_en    = {NCORES{state_q == START}};
    assign core_abort = (state_q == ABORT);
    assign key        = key_q;
    assign key_valid  = key_vld_q;
    assign win_idx    = win_q;
endmodule

// File: tb/tb_crack_scheduler.sv
// Directed bench for crack_scheduler with two behavioural core stand-ins and a CT memory where mem[i]=i.
module tb_crack_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic        key_valid;
    logic [2:0]  win_idx;
    logic [1:0]  core_en;
    logic [47:0] core_base;
    logic        core_abort;
    logic [1:0]  core_rdy;
    logic [47:0] core_key;
    logic [1:0]  core_key_valid;
    logic [1:0]  core_ct_req;
    logic [15:0] core_ct_addr;
    logic [1:0]  core_ct_gnt;
    logic [1:0]  core_ct_rvalid;
    logic [7:0]  core_ct_rddata;
    logic [7:0]  ct_addr;
    logic [7:0]  ct_rddata;
    logic [7:0]  ct_mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ct_rddata <= ct_mem[ct_addr];

    crack_scheduler #(.NCORES(2), .KEYW(24)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .rdy            (rdy),
        .key            (key),
        .key_valid      (key_valid),
        .win_idx        (win_idx),
        .core_en        (core_en),
        .core_base      (core_base),
        .core_abort     (core_abort),
        .core_rdy       (core_rdy),
        .core_key       (core_key),
        .core_key_valid (core_key_valid),
        .core_ct_req    (core_ct_req),
        .core_ct_addr   (core_ct_addr),
        .core_ct_gnt    (core_ct_gnt),
        .core_ct_rvalid (core_ct_rvalid),
        .core_ct_rddata (core_ct_rddata),
        .ct_addr        (ct_addr),
        .ct_rddata      (ct_rddata)
    );

    // Pulse en, wait (bounded) for the start pulse, then make both cores busy.
    // Returns at the negedge inside the first RUN cycle.
    task automatic start_run();
        int n = 0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        while (core_en !== 2'b11 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (core_en !== 2'b11) begin
            errors++;
            $display("FAIL start_run_core_en got=%b want=11", core_en);
        end
        core_rdy = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        core_rdy = 2'b11;
        core_key = '0;
        core_key_valid = 2'b00;
        core_ct_req = 2'b00;
        core_ct_addr = '0;
        repeat (2) @(negedge clk);
        checks += 8;
        if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b want=1", rdy); end
        if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got=%b want=0", key_valid); end
        if (key !== 24'h0) begin errors++; $display("FAIL reset_key got=%h want=000000", key); end
        if (core_en !== 2'b00) begin errors++; $display("FAIL reset_core_en got=%b want=00", core_en); end
        if (core_abort !== 1'b0) begin errors++; $display("FAIL reset_core_abort got=%b want=0", core_abort); end
        if (core_base !== {24'h000001, 24'h000000}) begin errors++; $display("FAIL reset_core_base got=%h want=000001000000", core_base); end
        if (ct_addr !== 8'h00) begin errors++; $display("FAIL reset_ct_addr got=%h want=00", ct_addr); end
        if (core_ct_rvalid !== 2'b00 || core_ct_gnt !== 2'b00) begin
            errors++; $display("FAIL reset_arb gnt=%b rvalid=%b want=00/00", core_ct_gnt, core_ct_rvalid);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rdy !== 1'b1 || core_en !== 2'b00) begin
            errors++; $display("FAIL idle_after_reset rdy=%b core_en=%b want=1/00", rdy, core_en);
        end
    endtask

    task automatic test_start();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checks += 2;
        if (rdy !== 1'b0) begin errors++; $display("FAIL start_waitc_rdy got=%b want=0", rdy); end
        if (core_en !== 2'b00) begin errors++; $display("FAIL start_waitc_core_en got=%b want=00", core_en); end
        @(negedge clk);
        checks += 2;
        if (core_en !== 2'b11) begin errors++; $display("FAIL start_pulse_core_en got=%b want=11", core_en); end
        if (rdy !== 1'b0) begin errors++; $display("FAIL start_pulse_rdy got=%b want=0", rdy); end
        core_rdy = 2'b00;
        @(negedge clk);
        checks++;
        if (core_en !== 2'b00) begin errors++; $display("FAIL start_one_cycle_core_en got=%b want=00", core_en); end
        en = 1'b1;
    endtask

    task automatic test_winner();
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL en_ignored_rdy got=%b want=0", rdy); end
        core_rdy = 2'b10;
        core_key = {24'h00001F, 24'h000AAA};
        core_key_valid = 2'b10;
        @(negedge clk);
        checks += 5;
        if (core_abort !== 1'b1) begin errors++; $display("FAIL win_abort got=%b want=1", core_abort); end
        if (key !== 24'h00001F) begin errors++; $display("FAIL win_key got=%h want=00001f", key); end
        if (win_idx !== 3'd1) begin errors++; $display("FAIL win_idx got=%0d want=1", win_idx); end
        if (key_valid !== 1'b1) begin errors++; $display("FAIL win_key_valid got=%b want=1", key_valid); end
        if (rdy !== 1'b0) begin errors++; $display("FAIL win_rdy got=%b want=0", rdy); end
        core_key = {24'h123456, 24'h000BBB};
        core_key_valid = 2'b00;
        @(negedge clk);
        checks += 2;
        if (core_abort !== 1'b1) begin errors++; $display("FAIL abort_hold got=%b want=1", core_abort); end
        if (key !== 24'h00001F) begin errors++; $display("FAIL abort_key_stable got=%h want=00001f", key); end
        core_rdy = 2'b11;
        @(negedge clk);
        checks += 4;
        if (rdy !== 1'b1) begin errors++; $display("FAIL abort_done_rdy got=%b want=1", rdy); end
        if (core_abort !== 1'b0) begin errors++; $display("FAIL abort_done_abort got=%b want=0", core_abort); end
        if (key !== 24'h00001F || win_idx !== 3'd1) begin
            errors++; $display("FAIL abort_done_result key=%h idx=%0d want=00001f/1", key, win_idx);
        end
        if (key_valid !== 1'b1) begin errors++; $display("FAIL abort_done_key_valid got=%b want=1", key_valid); end
    endtask

    task automatic test_simultaneous();
        start_run();
        @(negedge clk);
        core_rdy = 2'b11;
        core_key = {24'h000011, 24'h000010};
        core_key_valid = 2'b11;
        @(negedge clk);
        core_key_valid = 2'b00;
        checks += 3;
        if (key !== 24'h000010) begin errors++; $display("FAIL simul_key got=%h want=000010", key); end
        if (win_idx !== 3'd0) begin errors++; $display("FAIL simul_win_idx got=%0d want=0", win_idx); end
        if (key_valid !== 1'b1) begin errors++; $display("FAIL simul_key_valid got=%b want=1", key_valid); end
        @(negedge clk);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL simul_rdy got=%b want=1", rdy); end
    endtask

    task automatic test_all_invalid();
        start_run();
        @(negedge clk);
        core_rdy = 2'b01;
        core_key = {24'h000077, 24'h000066};
        core_key_valid = 2'b00;
        @(negedge clk);
        checks += 3;
        if (rdy !== 1'b0) begin errors++; $display("FAIL invalid_partial_rdy got=%b want=0", rdy); end
        if (core_abort !== 1'b0) begin errors++; $display("FAIL invalid_partial_abort got=%b want=0", core_abort); end
        if (key_valid !== 1'b0) begin errors++; $display("FAIL invalid_cleared_key_valid got=%b want=0", key_valid); end
        core_rdy = 2'b11;
        @(negedge clk);
        checks += 3;
        if (rdy !== 1'b1) begin errors++; $display("FAIL invalid_rdy got=%b want=1", rdy); end
        if (key_valid !== 1'b0) begin errors++; $display("FAIL invalid_key_valid got=%b want=0", key_valid); end
        if (core_abort !== 1'b0) begin errors++; $display("FAIL invalid_abort got=%b want=0", core_abort); end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_g;
        logic [1:0] prev_g;
        logic [7:0] exp_a;
        @(negedge clk);
        core_ct_addr = {8'h09, 8'h05};
        core_ct_req = 2'b11;
        exp_g = 2'b01;
        prev_g = 2'b00;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_a = (exp_g == 2'b01) ? 8'h05 : 8'h09;
            checks += 3;
            if (core_ct_gnt !== exp_g) begin errors++; $display("FAIL arb_gnt[%0d] got=%b want=%b", k, core_ct_gnt, exp_g); end
            if (ct_addr !== exp_a) begin errors++; $display("FAIL arb_addr[%0d] got=%h want=%h", k, ct_addr, exp_a); end
            if (core_ct_rvalid !== prev_g) begin errors++; $display("FAIL arb_rvalid[%0d] got=%b want=%b", k, core_ct_rvalid, prev_g); end
            if (prev_g != 2'b00) begin
                checks++;
                if (core_ct_rddata !== ((prev_g == 2'b01) ? 8'h05 : 8'h09)) begin
                    errors++; $display("FAIL arb_rddata[%0d] got=%h prev_gnt=%b", k, core_ct_rddata, prev_g);
                end
            end
            prev_g = exp_g;
            exp_g = {exp_g[0], exp_g[1]};
            @(negedge clk);
        end
        core_ct_req = 2'b00;
        #1;
        checks += 3;
        if (core_ct_gnt !== 2'b00) begin errors++; $display("FAIL arb_idle_gnt got=%b want=00", core_ct_gnt); end
        if (ct_addr !== 8'h09) begin errors++; $display("FAIL arb_hold_addr got=%h want=09", ct_addr); end
        if (core_ct_rvalid !== 2'b10 || core_ct_rddata !== 8'h09) begin
            errors++; $display("FAIL arb_last_read rvalid=%b data=%h want=10/09", core_ct_rvalid, core_ct_rddata);
        end
        @(negedge clk);
        core_ct_req = 2'b10;
        #1;
        checks++;
        if (core_ct_gnt !== 2'b10) begin errors++; $display("FAIL arb_single_gnt got=%b want=10", core_ct_gnt); end
        @(negedge clk);
        core_ct_req = 2'b00;
    endtask

    task automatic test_mid_reset();
        start_run();
        core_ct_req = 2'b11;
        #1;
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL midrst_pre_rdy got=%b want=0", rdy); end
        #1 rst_n = 1'b0;
        #1;
        checks += 6;
        if (rdy !== 1'b1) begin errors++; $display("FAIL midrst_rdy got=%b want=1", rdy); end
        if (key !== 24'h0 || key_valid !== 1'b0) begin errors++; $display("FAIL midrst_key key=%h kv=%b want=0/0", key, key_valid); end
        if (win_idx !== 3'd0) begin errors++; $display("FAIL midrst_win_idx got=%0d want=0", win_idx); end
        if (core_en !== 2'b00 || core_abort !== 1'b0) begin errors++; $display("FAIL midrst_ctl en=%b abort=%b want=00/0", core_en, core_abort); end
        if (core_ct_gnt !== 2'b00 || core_ct_rvalid !== 2'b00) begin errors++; $display("FAIL midrst_arb gnt=%b rvalid=%b want=00/00", core_ct_gnt, core_ct_rvalid); end
        if (ct_addr !== 8'h00) begin errors++; $display("FAIL midrst_ct_addr got=%h want=00", ct_addr); end
        core_ct_req = 2'b00;
        core_rdy = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ct_mem[i] = 8'(i);
        test_reset();
        test_start();
        test_winner();
        test_simultaneous();
        test_all_invalid();
        test_arbitration();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
